// File: rtl/wakeup_issue_queue_if.sv
// Dispatch, writeback-broadcast and issue signals of the wakeup issue queue.
// The master modport is the pipeline side; the slave modport is the queue.
interface wakeup_issue_queue_if #(
  parameter int DEPTH       = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int TAG_WIDTH   = 5,
  parameter int ID_WIDTH    = 4,
  parameter int WB_PORTS    = 2
);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                          enq_valid;
  logic                          enq_ready;
  logic [INSTR_WIDTH-1:0]        enq_instr;
  logic [ID_WIDTH-1:0]           enq_id;
  logic [TAG_WIDTH-1:0]          enq_src1;
  logic                          enq_src1_rdy;
  logic [TAG_WIDTH-1:0]          enq_src2;
  logic                          enq_src2_rdy;
  logic [TAG_WIDTH-1:0]          enq_dst;
  logic [WB_PORTS-1:0]           wb_valid;
  logic [WB_PORTS*TAG_WIDTH-1:0] wb_tag;
  logic                          iss_valid;
  logic                          iss_ready;
  logic [INSTR_WIDTH-1:0]        iss_instr;
  logic [ID_WIDTH-1:0]           iss_id;
  logic [TAG_WIDTH-1:0]          iss_dst;
  logic [CNT_WIDTH-1:0]          count;

  modport master (
    output enq_valid, enq_instr, enq_id, enq_src1, enq_src1_rdy,
           enq_src2, enq_src2_rdy, enq_dst, wb_valid, wb_tag, iss_ready,
    input  enq_ready, iss_valid, iss_instr, iss_id, iss_dst, count
  );

  modport slave (
    input  enq_valid, enq_instr, enq_id, enq_src1, enq_src1_rdy,
           enq_src2, enq_src2_rdy, enq_dst, wb_valid, wb_tag, iss_ready,
    output enq_ready, iss_valid, iss_instr, iss_id, iss_dst, count
  );
endinterface

// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue: tag-broadcast wakeup, oldest-ready select via an
// age matrix, valid/ready issue handshake and full flush.
module wakeup_issue_queue #(
  parameter int DEPTH       = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int TAG_WIDTH   = 5,
  parameter int ID_WIDTH    = 4,
  parameter int WB_PORTS    = 2
) (
  input logic               clk,
  input logic               reset,
  input logic               flush,
  wakeup_issue_queue_if.slave q
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]       valid;
  logic [DEPTH-1:0]       src1_rdy;
  logic [DEPTH-1:0]       src2_rdy;
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [ID_WIDTH-1:0]    id_q    [DEPTH];
  logic [TAG_WIDTH-1:0]   src1_q  [DEPTH];
  logic [TAG_WIDTH-1:0]   src2_q  [DEPTH];
  logic [TAG_WIDTH-1:0]   dst_q   [DEPTH];
  // older_than[i][j] set means entry j was enqueued before entry i.
  logic [DEPTH-1:0][DEPTH-1:0] older_than;
  logic [CNT_W-1:0]       count_q;

  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] sel_oh;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             any_cand;
  logic             enq_fire;
  logic             iss_fire;

  function automatic logic wb_hit(
    input logic [TAG_WIDTH-1:0]          tag,
    input logic [WB_PORTS-1:0]           vld,
    input logic [WB_PORTS*TAG_WIDTH-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (vld[p] && (tags[p*TAG_WIDTH +: TAG_WIDTH] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic init_rdy(
    input logic                          rdy,
    input logic [TAG_WIDTH-1:0]          tag,
    input logic [WB_PORTS-1:0]           vld,
    input logic [WB_PORTS*TAG_WIDTH-1:0] tags
  );
    return rdy || (tag == '0) || wb_hit(tag, vld, tags);
  endfunction

  assign q.enq_ready = (count_q != CNT_W'(DEPTH));
  assign q.count     = count_q;
  assign enq_fire    = q.enq_valid && q.enq_ready;
  assign iss_fire    = any_cand && q.iss_ready;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  // An entry wins when it is a candidate and no other candidate is older.
  always_comb begin
    cand    = valid & src1_rdy & src2_rdy;
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = cand[i] && !(|(cand & older_than[i]));
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    any_cand = |cand;
  end

  always_comb begin
    q.iss_valid = any_cand;
    q.iss_instr = '0;
    q.iss_id    = '0;
    q.iss_dst   = '0;
    if (any_cand) begin
      q.iss_instr = instr_q[sel_idx];
      q.iss_id    = id_q[sel_idx];
      q.iss_dst   = dst_q[sel_idx];
    end
  end

  // Control state: occupancy, count and age ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      count_q    <= '0;
      older_than <= '0;
    end else if (flush) begin
      valid   <= '0;
      count_q <= '0;
    end else begin
      if (iss_fire) valid[sel_idx] <= 1'b0;
      if (enq_fire) begin
        valid[free_idx] <= 1'b1;
        for (int i = 0; i < DEPTH; i++) older_than[i][free_idx] <= 1'b0;
        older_than[free_idx] <= ~({{(DEPTH-1){1'b0}}, 1'b1} << free_idx);
      end
      case ({enq_fire, iss_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload and operand readiness; meaningful only while the entry is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit(src1_q[i], q.wb_valid, q.wb_tag)) src1_rdy[i] <= 1'b1;
      if (wb_hit(src2_q[i], q.wb_valid, q.wb_tag)) src2_rdy[i] <= 1'b1;
    end
    if (enq_fire) begin
      instr_q[free_idx]  <= q.enq_instr;
      id_q[free_idx]     <= q.enq_id;
      src1_q[free_idx]   <= q.enq_src1;
      src2_q[free_idx]   <= q.enq_src2;
      dst_q[free_idx]    <= q.enq_dst;
      src1_rdy[free_idx] <= init_rdy(q.enq_src1_rdy, q.enq_src1, q.wb_valid, q.wb_tag);
      src2_rdy[free_idx] <= init_rdy(q.enq_src2_rdy, q.enq_src2, q.wb_valid, q.wb_tag);
    end
  end
endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Scoreboard bench for wakeup_issue_queue: an in-order reference list predicts
// each issue; predictions are queued and matched against the DUT's issues.
module tb_wakeup_issue_queue;
  localparam int DEPTH = 16;
  localparam int IW    = 32;
  localparam int TW    = 5;
  localparam int IDW   = 4;
  localparam int WBP   = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  wakeup_issue_queue_if #(.DEPTH(DEPTH), .INSTR_WIDTH(IW), .TAG_WIDTH(TW),
                          .ID_WIDTH(IDW), .WB_PORTS(WBP)) q_if ();

  wakeup_issue_queue #(.DEPTH(DEPTH), .INSTR_WIDTH(IW), .TAG_WIDTH(TW),
                       .ID_WIDTH(IDW), .WB_PORTS(WBP)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (q_if)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [IW-1:0]  instr;
    logic [TW-1:0]  dst;
    logic [TW-1:0]  s1;
    logic [TW-1:0]  s2;
    logic           r1;
    logic           r2;
  } ent_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [IW-1:0]  instr;
    logic [TW-1:0]  dst;
  } iss_t;

  ent_t mq[$];
  iss_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input logic [TW-1:0] tag);
    logic h;
    h = 1'b0;
    for (int p = 0; p < WBP; p++) begin
      if (q_if.wb_valid[p] && q_if.wb_tag[p*TW +: TW] == tag) h = 1'b1;
    end
    return h;
  endfunction

  task automatic set_enq(input int id, input int s1, input bit r1, input int s2,
                         input bit r2, input int dst);
    q_if.enq_valid    = 1'b1;
    q_if.enq_id       = IDW'(id);
    q_if.enq_instr    = {16'hC0DE, 8'h00, 8'(id * 7 + dst)};
    q_if.enq_src1     = TW'(s1);
    q_if.enq_src1_rdy = r1;
    q_if.enq_src2     = TW'(s2);
    q_if.enq_src2_rdy = r2;
    q_if.enq_dst      = TW'(dst);
  endtask

  task automatic clear_inputs();
    q_if.enq_valid = 1'b0;
    q_if.wb_valid  = '0;
    q_if.wb_tag    = '0;
    flush          = 1'b0;
    reset          = 1'b0;
  endtask

  // One clock: compare registered-state outputs, predict issue, advance model.
  task automatic cycle();
    int   sel;
    logic iv, ef, isf;
    iss_t rec;
    ent_t e;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    iv = (sel >= 0);
    @(negedge clk);
    check_eq("count", 64'(q_if.count), 64'(mq.size()));
    check_eq("enq_ready", 64'(q_if.enq_ready), 64'(mq.size() != DEPTH));
    check_eq("iss_valid", 64'(q_if.iss_valid), 64'(iv));
    if (!q_if.iss_valid)
      check_eq("iss_zero", 64'({q_if.iss_instr, q_if.iss_id, q_if.iss_dst}), 64'd0);
    ef  = q_if.enq_valid && (mq.size() != DEPTH) && !reset && !flush;
    isf = iv && q_if.iss_ready && !reset && !flush;
    if (isf) sb.push_back('{mq[sel].id, mq[sel].instr, mq[sel].dst});
    if (q_if.iss_valid && q_if.iss_ready && !reset && !flush) begin
      check_eq("sb_avail", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        rec = sb.pop_front();
        check_eq("iss_id", 64'(q_if.iss_id), 64'(rec.id));
        check_eq("iss_instr", 64'(q_if.iss_instr), 64'(rec.instr));
        check_eq("iss_dst", 64'(q_if.iss_dst), 64'(rec.dst));
      end
    end
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
    end else begin
      foreach (mq[i]) begin
        if (hit(mq[i].s1)) mq[i].r1 = 1'b1;
        if (hit(mq[i].s2)) mq[i].r2 = 1'b1;
      end
      if (isf) mq.delete(sel);
      if (ef) begin
        e.id    = q_if.enq_id;
        e.instr = q_if.enq_instr;
        e.dst   = q_if.enq_dst;
        e.s1    = q_if.enq_src1;
        e.s2    = q_if.enq_src2;
        e.r1    = q_if.enq_src1_rdy || (q_if.enq_src1 == '0) || hit(q_if.enq_src1);
        e.r2    = q_if.enq_src2_rdy || (q_if.enq_src2 == '0) || hit(q_if.enq_src2);
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    q_if.iss_ready = 1'b1;
    set_enq(0, 0, 0, 0, 0, 0);
    q_if.enq_valid = 1'b0;
    idle_cycles(2);
    clear_inputs();
    cycle();

    // Single ready entry issues the cycle after enqueue.
    set_enq(3, 4, 1, 0, 0, 6);
    cycle();
    q_if.enq_valid = 1'b0;
    check_eq("t1_count", 64'(q_if.count), 64'd1);
    check_eq("t1_id", 64'(q_if.iss_id), 64'd3);
    idle_cycles(2);

    // Younger ready entry bypasses an older blocked one; wakeup via port 1.
    q_if.iss_ready = 1'b0;
    set_enq(1, 7, 0, 3, 1, 8);
    cycle();
    set_enq(2, 2, 1, 3, 1, 9);
    cycle();
    q_if.enq_valid = 1'b0;
    q_if.iss_ready = 1'b1;
    check_eq("t2_id", 64'(q_if.iss_id), 64'd2);
    cycle();
    q_if.wb_valid = 2'b10;
    q_if.wb_tag   = {5'd7, 5'd0};
    cycle();
    q_if.wb_valid = '0;
    check_eq("t2_wake", 64'(q_if.iss_id), 64'd1);
    idle_cycles(2);

    // Fill with entries waiting on tag 9, then wake all with a duplicated tag.
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(i, 9, 0, 0, 0, i + 1);
      cycle();
    end
    q_if.enq_valid = 1'b0;
    check_eq("t3_full", 64'(q_if.count), 64'd16);
    check_eq("t3_stall", 64'(q_if.enq_ready), 64'd0);
    q_if.wb_valid = 2'b11;
    q_if.wb_tag   = {5'd9, 5'd9};
    cycle();
    q_if.wb_valid = '0;
    idle_cycles(DEPTH + 1);

    // Enqueue-time bypass from port 0.
    set_enq(5, 5, 0, 0, 0, 11);
    q_if.wb_valid = 2'b01;
    q_if.wb_tag   = {5'd0, 5'd5};
    cycle();
    clear_inputs();
    check_eq("t4_bypass", 64'(q_if.iss_valid), 64'd1);
    idle_cycles(2);

    // Full queue with issue and enqueue in the same cycle: enqueue is held once.
    q_if.iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(i, 0, 0, 1, 1, i);
      cycle();
    end
    q_if.iss_ready = 1'b1;
    set_enq(10, 0, 0, 0, 0, 20);
    cycle();
    check_eq("t5_held", 64'(q_if.count), 64'd15);
    cycle();
    q_if.enq_valid = 1'b0;
    check_eq("t5_accept", 64'(q_if.count), 64'd15);
    idle_cycles(DEPTH + 1);

    // Flush dominates a same-cycle enqueue and issue.
    q_if.iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(i + 4, 0, 0, 0, 0, i);
      cycle();
    end
    q_if.iss_ready = 1'b1;
    flush = 1'b1;
    set_enq(12, 0, 0, 0, 0, 3);
    cycle();
    clear_inputs();
    check_eq("t6_flush", 64'(q_if.count), 64'd0);
    cycle();

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) begin
      set_enq(i + 8, 0, 0, 0, 0, i);
      cycle();
    end
    q_if.enq_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("t7_reset", 64'(q_if.count), 64'd0);
    cycle();

    // Random mixed traffic on a small tag space.
    for (int k = 0; k < 400; k++) begin
      q_if.enq_valid = 1'b0;
      if ($urandom_range(0, 3) != 0)
        set_enq($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                $urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 31));
      q_if.wb_valid  = WBP'($urandom_range(0, 3));
      q_if.wb_tag    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      q_if.iss_ready = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear_inputs();
    q_if.iss_ready = 1'b1;
    q_if.wb_valid  = 2'b11;
    for (int t = 1; t < 8; t += 2) begin
      q_if.wb_tag = {5'(t), 5'(t - 1)};
      cycle();
    end
    q_if.wb_valid = '0;
    idle_cycles(DEPTH + 2);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wakeup_issue_queue.md
Name: wakeup_issue_queue

Overview:
- Parametrised out-of-order issue queue that sits between rename/dispatch and the execution units.
- Holds up to DEPTH instructions with per-operand ready bits and watches WB_PORTS writeback tag broadcasts to wake up waiting operands.
- Each cycle it issues the oldest entry whose operands are both ready, under a valid/ready handshake, and supports a full flush.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
INSTR_WIDTH, 32, instruction payload width
TAG_WIDTH, 5, register tag width; tag 0 is the hard-wired zero register
ID_WIDTH, 4, instruction ID width
WB_PORTS, 2, number of writeback broadcast ports

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  invalidate all entries
enq_valid  input  1  dispatch offers an instruction
enq_ready  output  1  queue can accept; equals (count != DEPTH)
enq_instr  input  INSTR_WIDTH  instruction payload
enq_id  input  ID_WIDTH  instruction ID
enq_src1  input  TAG_WIDTH  source 1 tag
enq_src1_rdy  input  1  source 1 already available
enq_src2  input  TAG_WIDTH  source 2 tag
enq_src2_rdy  input  1  source 2 already available
enq_dst  input  TAG_WIDTH  destination tag
wb_valid  input  WB_PORTS  per-port writeback valid
wb_tag  input  WB_PORTS*TAG_WIDTH  per-port writeback tag; port p occupies bits [p*TAG_WIDTH +: TAG_WIDTH]
iss_valid  output  1  a selected entry is presented
iss_ready  input  1  execution unit accepts
iss_instr  output  INSTR_WIDTH  selected payload
iss_id  output  ID_WIDTH  selected ID
iss_dst  output  TAG_WIDTH  selected destination tag
count  output  $clog2(DEPTH)+1  occupied entries, range 0..DEPTH

Behaviour:
- Reset (synchronous, active-high):
  - all entries invalid, count=0, age state cleared.
  - iss_valid=0, enq_ready=1, iss_* data outputs 0.
  - reset asserted mid-operation discards every entry on that edge.
- Enqueue:
  - fires on enq_valid & enq_ready.
  - writes the lowest-index free entry; the entry is marked valid and youngest.
- Initial ready bit per source = enq_srcN_rdy OR (srcN == 0) OR a same-cycle wb_valid[p] with wb_tag[p] == srcN (enqueue-time bypass).
- Wakeup:
  - each cycle, every valid entry sets its srcN ready bit if any wb_valid[p] carries a tag equal to srcN.
  - a ready bit never clears while the entry is valid.
- Select (combinational from registered state):
  - candidates are entries with valid & src1_rdy & src2_rdy.
  - iss_valid = at least one candidate; the oldest candidate is chosen, with age tracked by a DEPTH x DEPTH age matrix.
  - iss_instr/iss_id/iss_dst come from the selected entry; they are 0 when iss_valid=0.
- Issue:
  - on iss_valid & iss_ready the selected entry is freed at the clock edge.
  - while iss_ready=0 the selection may change only if an older entry becomes ready.
- Latency:
  - enqueue with both sources ready -> iss_valid the next cycle.
  - wakeup broadcast at cycle N -> dependent entry is eligible at N+1.
  - there is no same-cycle enqueue-to-issue path.
- Simultaneous enqueue and issue:
  - count is unchanged; a freed slot is not reusable in the same cycle.
  - enq_ready depends only on the registered count, so when full, enqueue stalls one cycle even if an issue happens.
- Count update: +1 on enqueue only, -1 on issue only; it never wraps.
  - Full: count==DEPTH, enq_ready=0.
  - Empty: count==0, iss_valid=0.
- Flush:
  - all entries invalidated and count=0 on the edge.
  - flush dominates a same-cycle enqueue (dropped) and issue (no entry freed twice).
  - reset dominates flush.
- Multiple wb ports may carry the same tag in one cycle; the effect is identical to a single match.

Test Plan:
- Reset, then enqueue id=3, src1=4 rdy, src2=0 -> next cycle iss_valid=1, iss_id=3; with iss_ready=1 count goes 1->0.
- Enqueue id=1 (src1=7 not ready), then id=2 (ready) -> id=2 issues first. Then drive wb_valid[1]=1, wb_tag=7 -> id=1 has iss_valid the following cycle.
- Enqueue 16 entries with src1=9 not ready -> count=16, enq_ready=0, iss_valid=0. Broadcast tag 9 -> ids issue oldest-first, one per cycle, over 16 cycles with iss_ready=1.
- Enqueue src1=5 in the same cycle as wb tag 5 -> bypass sets ready; entry issues the next cycle.
- Full queue, iss_ready=1 plus enq_valid -> count drops to 15 and the enqueue is held one cycle, accepted the next.
- Flush with enq_valid=1 and iss_valid=1 -> count=0, iss_valid=0 next cycle, nothing enqueued. Assert reset mid-drain -> same empty state.
